// File: rtl/ctrl_mmio_bank_pkg.sv
// Shared definitions for the controller MMIO bank.
//   - cnt_width(): debounce counter width for a given stable-cycle count
//   - off_state/off_evt/off_out(): word offsets inside the block
//   - base_range_ok(): checks that the block does not wrap the address space
//   - word_kind_e: what an address offset selects
package ctrl_mmio_bank_pkg;

    typedef enum logic [1:0] {
        WORD_STATE = 2'd0,
        WORD_EVT   = 2'd1,
        WORD_OUT   = 2'd2,
        WORD_NONE  = 2'd3
    } word_kind_e;

    // Width needed to hold 0..cycles.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    function automatic int unsigned off_state(input int unsigned p);
        return 2 * p;
    endfunction

    function automatic int unsigned off_evt(input int unsigned p);
        return 2 * p + 1;
    endfunction

    function automatic int unsigned off_out(input int unsigned num_players);
        return 2 * num_players;
    endfunction

    // The output word is the highest offset; it must sit below 2^addr_w.
    function automatic bit base_range_ok(input longint base,
                                         input longint num_players,
                                         input int     addr_w);
        return (base + 2 * num_players) < (longint'(1) << addr_w);
    endfunction

endpackage

// File: rtl/ctrl_mmio_bank_channel.sv
// One controller channel: 2-flop synchroniser, whole-vector debounce and
// sticky rising-edge event register.
// Ports:
//   clock, reset_btn  clock and async active-low reset
//   pins_i            raw asynchronous pins
//   clr_i             clear all event bits this cycle (a new rise still sets)
//   state_o           debounced stable state
//   evt_o             sticky debounced 0->1 events
module ctrl_channel
    import ctrl_mmio_bank_pkg::*;
#(
    parameter int BTNS            = 18,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic            clock,
    input  logic            reset_btn,
    input  logic [BTNS-1:0] pins_i,
    input  logic            clr_i,
    output logic [BTNS-1:0] state_o,
    output logic [BTNS-1:0] evt_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [BTNS-1:0]  sync1_q, sync2_q, prev_q;
    logic [BTNS-1:0]  stable_q, stable_d;
    logic [BTNS-1:0]  evt_q, evt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any movement of the sampled vector restarts the stability window;
    // the state only moves once the new value has held for the full count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q != prev_q) begin
            cnt_d = '0;
        end else if (sync2_q != stable_q) begin
            if (cnt_q == CNT_TC) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Set has priority over clear so a rise coinciding with a read is kept.
    assign evt_d = (evt_q & ~{BTNS{clr_i}}) | (stable_d & ~stable_q);

    always_ff @(posedge clock or negedge reset_btn) begin
        if (!reset_btn) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            stable_q <= '0;
            evt_q    <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= pins_i;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            stable_q <= stable_d;
            evt_q    <= evt_d;
            cnt_q    <= cnt_d;
        end
    end

    assign state_o = stable_q;
    assign evt_o   = evt_q;

endmodule

// File: rtl/ctrl_mmio_bank.sv
// Memory-mapped bank of NUM_PLAYERS debounced controller channels plus a
// writable output register.
// Word map relative to BASE_ADDR: 2p = state[p], 2p+1 = events[p]
// (clear-on-read when rden without wren), 2*NUM_PLAYERS = gpioOutput.
// Ports:
//   clock, reset_btn   clock and async active-low reset
//   address, data_in   dmem word address and write data
//   wren, rden         write strobe, read strobe (gates clear-on-read)
//   data_out, hit      registered read data and in-range flag (1-cycle latency)
//   gpio               raw pins, channel p at [p*BTNS +: BTNS]
//   gpioOutput         output register
//   btn_state          debounced state, same packing as gpio
module ctrl_mmio_bank
    import ctrl_mmio_bank_pkg::*;
#(
    parameter int                NUM_PLAYERS     = 2,
    parameter int                BTNS            = 18,
    parameter int                DEBOUNCE_CYCLES = 50000,
    parameter int                ADDR_W          = 13,
    parameter logic [ADDR_W-1:0] BASE_ADDR       = 'h1F00,
    parameter int                OUT_W           = 3
) (
    input  logic                        clock,
    input  logic                        reset_btn,
    input  logic [ADDR_W-1:0]           address,
    input  logic [31:0]                 data_in,
    input  logic                        wren,
    input  logic                        rden,
    output logic [31:0]                 data_out,
    output logic                        hit,
    input  logic [NUM_PLAYERS*BTNS-1:0] gpio,
    output logic [OUT_W-1:0]            gpioOutput,
    output logic [NUM_PLAYERS*BTNS-1:0] btn_state
);

    localparam int unsigned OUT_OFF = off_out(NUM_PLAYERS);
    localparam int          PW      = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

    if (!base_range_ok(longint'(BASE_ADDR), longint'(NUM_PLAYERS), ADDR_W)) begin : g_range_err
        $error("ctrl_mmio_bank: BASE_ADDR + 2*NUM_PLAYERS wraps the address space");
    end

    logic [ADDR_W-1:0] off;
    word_kind_e        kind;
    logic [PW-1:0]     chan;
    logic              rd_clr;
    logic [NUM_PLAYERS-1:0] clr;
    logic [BTNS-1:0]   state_arr [NUM_PLAYERS];
    logic [BTNS-1:0]   evt_arr   [NUM_PLAYERS];

    logic [31:0]       data_out_q, data_out_d;
    logic              hit_q, hit_d;
    logic [OUT_W-1:0]  gout_q, gout_d;

    // Subtraction wraps, so addresses below BASE_ADDR land far above the block.
    assign off = address - BASE_ADDR;

    always_comb begin
        kind = WORD_NONE;
        chan = '0;
        if (32'(off) < OUT_OFF) begin
            kind = off[0] ? WORD_EVT : WORD_STATE;
            chan = PW'(off >> 1);
        end else if (32'(off) == OUT_OFF) begin
            kind = WORD_OUT;
        end
    end

    // A simultaneous write takes precedence, so only a pure read clears.
    assign rd_clr = rden && !wren && (kind == WORD_EVT);

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_ch
        assign clr[p] = rd_clr && (chan == PW'(p));

        ctrl_channel #(
            .BTNS            (BTNS),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clock     (clock),
            .reset_btn (reset_btn),
            .pins_i    (gpio[p*BTNS +: BTNS]),
            .clr_i     (clr[p]),
            .state_o   (state_arr[p]),
            .evt_o     (evt_arr[p])
        );

        assign btn_state[p*BTNS +: BTNS] = state_arr[p];
    end

    // Events are sampled before the clear lands, so a read returns pre-clear bits.
    always_comb begin
        data_out_d = '0;
        case (kind)
            WORD_STATE: data_out_d = 32'(state_arr[chan]);
            WORD_EVT:   data_out_d = 32'(evt_arr[chan]);
            WORD_OUT:   data_out_d = 32'(gout_q);
            default:    data_out_d = '0;
        endcase
    end

    assign hit_d  = (kind != WORD_NONE);
    assign gout_d = (wren && kind == WORD_OUT) ? data_in[OUT_W-1:0] : gout_q;

    if (OUT_W < 32) begin : g_unused_data
        logic unused_data_hi;
        assign unused_data_hi = ^data_in[31:OUT_W];
    end

    always_ff @(posedge clock or negedge reset_btn) begin
        if (!reset_btn) begin
            data_out_q <= '0;
            hit_q      <= 1'b0;
            gout_q     <= '0;
        end else begin
            data_out_q <= data_out_d;
            hit_q      <= hit_d;
            gout_q     <= gout_d;
        end
    end

    assign data_out   = data_out_q;
    assign hit        = hit_q;
    assign gpioOutput = gout_q;

endmodule
